// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM state and sort-direction encodings for odd_even_sort.
package sort_pkg;
    typedef enum logic [1:0] {IDLE, SORT, OUT} state_t;
    localparam logic ASCEND  = 1'b0;
    localparam logic DESCEND = 1'b1;
endpackage

// File: rtl/cmp_swap.sv
// cmp_swap: one compare-exchange cell; o_lo/o_hi take the ordered pair for the given direction.
module cmp_swap
    import sort_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_dir,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hi
);
    logic w_swap;
    // strict compares so equal keys never move
    assign w_swap = (i_dir == DESCEND) ? (i_a < i_b) : (i_a > i_b);
    assign o_lo   = w_swap ? i_b : i_a;
    assign o_hi   = w_swap ? i_a : i_b;
endmodule

// File: rtl/odd_even_sort.sv
// odd_even_sort: latches DATA_N elements, runs DATA_N odd-even transposition passes,
// then streams the sorted elements out with a valid/ready handshake.
module odd_even_sort
    import sort_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DATA_N = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_sort,
    input  logic                     dir,
    input  logic [DATA_W-1:0]        data_in [DATA_N],
    output logic                     busy,
    output logic [DATA_W-1:0]        data_out,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_last,
    output logic [$clog2(DATA_N)-1:0] out_idx
);
    localparam int IW = $clog2(DATA_N);
    localparam int PW = $clog2(DATA_N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_N - 1);
    localparam logic [PW-1:0] PASSES   = PW'(DATA_N);

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_data [DATA_N];
    logic              r_dir;
    logic [PW-1:0]     r_pass;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] w_lo [DATA_N-1];
    logic [DATA_W-1:0] w_hi [DATA_N-1];
    logic [DATA_W-1:0] w_nxt [DATA_N];
    logic              w_hs;

    for (genvar p = 0; p < DATA_N - 1; p++) begin : g_cs
        cmp_swap #(.DATA_W(DATA_W)) u_cs (
            .i_a  (r_data[p]),
            .i_b  (r_data[p+1]),
            .i_dir(r_dir),
            .o_lo (w_lo[p]),
            .o_hi (w_hi[p])
        );
    end

    // even passes use cells (0,1),(2,3)..; odd passes use (1,2),(3,4)..; unpaired ends hold
    for (genvar e = 0; e < DATA_N; e++) begin : g_nxt
        logic [DATA_W-1:0] w_even, w_odd;
        if (e % 2 == 0 && e + 1 < DATA_N) assign w_even = w_lo[e];
        else if (e % 2 == 1)               assign w_even = w_hi[e-1];
        else                               assign w_even = r_data[e];
        if (e % 2 == 1 && e + 1 < DATA_N) assign w_odd = w_lo[e];
        else if (e % 2 == 0 && e > 0)      assign w_odd = w_hi[e-1];
        else                               assign w_odd = r_data[e];
        assign w_nxt[e] = r_pass[0] ? w_odd : w_even;
    end

    assign busy     = r_state != IDLE;
    assign out_vld  = r_state == OUT;
    assign out_idx  = r_idx;
    assign out_last = out_vld && (r_idx == LAST_IDX);
    assign data_out = out_vld ? r_data[r_idx] : '0;
    assign w_hs     = out_vld && out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start_sort ? SORT : IDLE;
            SORT:    w_next = (r_pass == PASSES) ? OUT : SORT;
            OUT:     w_next = (w_hs && out_last) ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '{default: '0};
            r_dir  <= ASCEND;
            r_pass <= '0;
            r_idx  <= '0;
        end else if (r_state == IDLE && start_sort) begin
            r_data <= data_in;
            r_dir  <= dir;
            r_pass <= '0;
            r_idx  <= '0;
        end else if (r_state == SORT && r_pass != PASSES) begin
            r_data <= w_nxt;
            r_pass <= r_pass + PW'(1);
        end else if (w_hs) begin
            r_idx <= out_last ? '0 : r_idx + IW'(1);
        end
    end
endmodule

// File: doc/odd_even_sort.md
ODD_EVEN_SORT -- requirements
Module: odd_even_sort

Interface
REQ-001 Parameters, one per line (name, default, meaning); each SHALL be honoured as listed:
  DATA_W, 4, element width in bits (>=1)
  DATA_N, 4, element count (>=2)
REQ-002 Ports, one per line (name, direction, width, meaning); the module SHALL provide exactly these:
  clk, input, 1, single clock; all logic on rising edge
  rst_n, input, 1, reset, asynchronous, active-low
  start_sort, input, 1, sort request pulse
  dir, input, 1, order: 0 ascending, 1 descending; sampled with start_sort
  data_in, input, DATA_N x DATA_W unpacked array, elements to sort
  busy, output, 1, high from accepted start until last output handshake
  data_out, output, DATA_W, current sorted element
  out_vld, output, 1, data_out valid
  out_rdy, input, 1, downstream ready
  out_last, output, 1, marks element DATA_N-1 of the stream
  out_idx, output, $clog2(DATA_N), position of data_out in sorted stream

Function
REQ-003 State machine (IDLE, SORT, OUT) SHALL have exactly these transitions: IDLE->SORT on start_sort; SORT->OUT after DATA_N passes; OUT->IDLE on handshake with out_last=1.
REQ-004 In IDLE, start_sort=1 SHALL latch all data_in elements and dir into internal registers on that edge; busy SHALL rise the next cycle.
REQ-005 start_sort SHALL be ignored in SORT and OUT; latched data and dir SHALL be unaffected.
REQ-006 SORT SHALL perform one odd-even transposition pass per cycle, exactly DATA_N passes: pass 0,2,.. compares pairs (0,1),(2,3),..; pass 1,3,.. compares pairs (1,2),(3,4),..; unpaired end elements hold.
REQ-007 Comparison SHALL be unsigned over DATA_W bits; swap only when strictly out of order for dir (equal keys never swap).
REQ-008 out_vld SHALL first assert exactly DATA_N+1 cycles after the edge that accepted start_sort, with out_idx=0.
REQ-009 OUT SHALL emit element 0..DATA_N-1 in order; out_idx SHALL advance only on the edge where out_vld=1 and out_rdy=1.
REQ-010 While out_vld=1 and out_rdy=0, data_out, out_idx and out_last SHALL hold stable.
REQ-011 out_last SHALL equal out_vld when out_idx=DATA_N-1, else 0.
REQ-012 After the last handshake, out_vld and busy SHALL be 0 on the next cycle; a start_sort on that next cycle SHALL be accepted.
REQ-013 When out_vld=0, data_out SHALL be 0.
REQ-014 A start_sort coincident with the final handshake SHALL be ignored (state is OUT on that edge).

Reset
REQ-015 rst_n low SHALL asynchronously force state IDLE, busy=0, out_vld=0, out_last=0, data_out=0, out_idx=0, and clear all element registers and dir to 0.
REQ-016 Reset asserted mid-SORT or mid-OUT SHALL abort the operation; no further out_vld until a new start_sort after reset release.
REQ-017 The first edge after rst_n deasserts SHALL accept start_sort.

Structure
REQ-018 Package sort_pkg SHALL hold the state enum (IDLE, SORT, OUT) and the dir encoding constants (ASCEND=0, DESCEND=1).
REQ-019 One sub-module cmp_swap SHALL implement a single compare-exchange (two DATA_W inputs, dir, two ordered outputs), instantiated via generate per pair.
REQ-020 Pass counter width SHALL be $clog2(DATA_N+1).

Verification
REQ-021 DATA_N=4, DATA_W=4, data_in={3,1,2,0}, dir=0, out_rdy=1 -> out stream 0,1,2,3 on consecutive cycles, first out_vld 5 cycles after start, out_last on 3.
REQ-022 Same data, dir=1 -> 3,2,1,0; out_idx 0..3.
REQ-023 data_in={5,5,5,5}, dir=0 -> 5,5,5,5; {15,0,15,0} -> 0,0,15,15.
REQ-024 out_rdy low for 3 cycles at out_idx=1 on {3,1,2,0}, dir=0 -> data_out=1 held 4 cycles, then 2,3; busy high throughout.
REQ-025 start_sort with data_in={9,9,9,9} during SORT of {3,1,2,0} -> output 0,1,2,3 unchanged.
REQ-026 rst_n low 2 cycles mid-SORT -> all outputs 0 immediately; new start with {2,3,1,0} -> 0,1,2,3; repeat REQ-021 with DATA_N=8 on {7,6,5,4,3,2,1,0} -> 0..7.
